// File: rtl/mem_issue_queue_if.sv
// rtl/mem_issue_queue_if.sv - dispatch-side enqueue handshake for the memory issue queue
interface mem_issue_queue_if #(
    parameter int WIDTH_REG = 5,
    parameter int WIDTH_BRM = 4
);
    logic                 i_enq_val;
    logic [6:0]           i_enq_uop;
    logic [9:0]           i_enq_func;
    logic [WIDTH_BRM-1:0] i_enq_brmask;
    logic [WIDTH_REG-1:0] i_enq_rd;
    logic [31:0]          i_enq_pc;
    logic [31:0]          i_enq_imm;
    logic [WIDTH_REG-1:0] i_enq_rs1;
    logic [WIDTH_REG-1:0] i_enq_rs2;
    logic                 i_enq_rdy1;
    logic                 i_enq_rdy2;
    logic [31:0]          i_enq_op1;
    logic [31:0]          i_enq_op2;
    logic                 o_ready;

    modport master (
        output i_enq_val, i_enq_uop, i_enq_func, i_enq_brmask, i_enq_rd, i_enq_pc, i_enq_imm,
               i_enq_rs1, i_enq_rs2, i_enq_rdy1, i_enq_rdy2, i_enq_op1, i_enq_op2,
        input  o_ready
    );

    modport slave (
        input  i_enq_val, i_enq_uop, i_enq_func, i_enq_brmask, i_enq_rd, i_enq_pc, i_enq_imm,
               i_enq_rs1, i_enq_rs2, i_enq_rdy1, i_enq_rdy2, i_enq_op1, i_enq_op2,
        output o_ready
    );
endinterface

// File: rtl/mem_issue_queue.sv
// rtl/mem_issue_queue.sv - in-order load/store issue queue with bypass wakeup and branch kill
// Optional same-cycle head wakeup: MEM_IQ_FAST_WAKEUP_EN
module mem_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int WIDTH_REG = 5,
    parameter int WIDTH_BRM = 4,
    parameter int WIDTH     = 4*32+WIDTH_REG+WIDTH_BRM+18
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    mem_issue_queue_if.slave          enq,
    input  logic [32+WIDTH_REG:0]     i_bypass_alu,
    input  logic [32+WIDTH_REG:0]     i_bypass_mem,
    input  logic                      i_br_kill,
    input  logic                      i_br_resolve,
    input  logic [WIDTH_BRM-1:0]      i_br_mask,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic [WIDTH-1:0]          o_instr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic                 q_valid  [DEPTH];
    logic [6:0]           q_uop    [DEPTH];
    logic [9:0]           q_func   [DEPTH];
    logic [WIDTH_BRM-1:0] q_brmask [DEPTH];
    logic [WIDTH_REG-1:0] q_rd     [DEPTH];
    logic [31:0]          q_pc     [DEPTH];
    logic [31:0]          q_imm    [DEPTH];
    logic [WIDTH_REG-1:0] q_rs1    [DEPTH];
    logic                 q_rdy1   [DEPTH];
    logic [31:0]          q_op1    [DEPTH];
    logic [WIDTH_REG-1:0] q_rs2    [DEPTH];
    logic                 q_rdy2   [DEPTH];
    logic [31:0]          q_op2    [DEPTH];

    logic [PW-1:0]        head, tail;
    logic [CW-1:0]        count, count_next;
    logic [WIDTH-1:0]     instr_q;

    logic                 alu_val, mem_val;
    logic [WIDTH_REG-1:0] alu_tag, mem_tag;
    logic [31:0]          alu_data, mem_data;

    logic                 ready, enq_acc, enq_killed;
    logic                 head_killed, pop_drop, pop_issue, popped;
    logic [WIDTH_BRM-1:0] res_mask;
    logic [32:0]          h_src1, h_src2, e_src1, e_src2;

    assign {alu_val, alu_tag, alu_data} = i_bypass_alu;
    assign {mem_val, mem_tag, mem_data} = i_bypass_mem;

    // Returns {rdy, value}; ALU bus is checked first so it wins a tie on the same tag.
    function automatic logic [32:0] wake(input logic rdy, input logic [WIDTH_REG-1:0] tag,
                                         input logic [31:0] op);
        if (rdy)
            return {1'b1, op};
        if (alu_val && alu_tag == tag)
            return {1'b1, alu_data};
        if (mem_val && mem_tag == tag)
            return {1'b1, mem_data};
        return {1'b0, op};
    endfunction

    // Kill outranks resolve: a resolve in a kill cycle is ignored.
    assign res_mask = (i_br_resolve && !i_br_kill) ? i_br_mask : '0;

    assign ready      = (count < DEPTH_C);
    assign enq_acc    = enq.i_enq_val && ready;
    assign enq_killed = i_br_kill && |(enq.i_enq_brmask & i_br_mask);
    assign e_src1     = wake(enq.i_enq_rdy1, enq.i_enq_rs1, enq.i_enq_op1);
    assign e_src2     = wake(enq.i_enq_rdy2, enq.i_enq_rs2, enq.i_enq_op2);

`ifdef MEM_IQ_FAST_WAKEUP_EN
    assign h_src1 = wake(q_rdy1[head], q_rs1[head], q_op1[head]);
    assign h_src2 = wake(q_rdy2[head], q_rs2[head], q_op2[head]);
`else
    assign h_src1 = {q_rdy1[head], q_op1[head]};
    assign h_src2 = {q_rdy2[head], q_op2[head]};
`endif

    assign head_killed = i_br_kill && |(q_brmask[head] & i_br_mask);
    assign pop_drop    = (count != '0) && !q_valid[head];
    assign pop_issue   = (count != '0) && q_valid[head] && h_src1[32] && h_src2[32] && !head_killed;
    assign popped      = pop_drop || pop_issue;
    assign count_next  = count + CW'(enq_acc) - CW'(popped);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            instr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_valid[i]  <= 1'b0;
                q_uop[i]    <= '0;
                q_func[i]   <= '0;
                q_brmask[i] <= '0;
                q_rd[i]     <= '0;
                q_pc[i]     <= '0;
                q_imm[i]    <= '0;
                q_rs1[i]    <= '0;
                q_rdy1[i]   <= 1'b0;
                q_op1[i]    <= '0;
                q_rs2[i]    <= '0;
                q_rdy2[i]   <= 1'b0;
                q_op2[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                {q_rdy1[i], q_op1[i]} <= wake(q_rdy1[i], q_rs1[i], q_op1[i]);
                {q_rdy2[i], q_op2[i]} <= wake(q_rdy2[i], q_rs2[i], q_op2[i]);
                q_brmask[i]           <= q_brmask[i] & ~res_mask;
                if (i_br_kill && |(q_brmask[i] & i_br_mask))
                    q_valid[i] <= 1'b0;
            end

            if (popped) begin
                q_valid[head] <= 1'b0;
                head          <= head + 1'b1;
            end

            // Tail never aliases a popping head: a full queue refuses dispatch.
            if (enq_acc) begin
                q_valid[tail]            <= !enq_killed;
                q_uop[tail]              <= enq.i_enq_uop;
                q_func[tail]             <= enq.i_enq_func;
                q_brmask[tail]           <= enq.i_enq_brmask & ~res_mask;
                q_rd[tail]               <= enq.i_enq_rd;
                q_pc[tail]               <= enq.i_enq_pc;
                q_imm[tail]              <= enq.i_enq_imm;
                q_rs1[tail]              <= enq.i_enq_rs1;
                q_rs2[tail]              <= enq.i_enq_rs2;
                {q_rdy1[tail], q_op1[tail]} <= e_src1;
                {q_rdy2[tail], q_op2[tail]} <= e_src2;
                tail                     <= tail + 1'b1;
            end

            count <= count_next;

            if (pop_issue)
                instr_q <= {1'b1, q_uop[head], q_brmask[head] & ~res_mask, q_rd[head], q_pc[head],
                            q_func[head], q_imm[head], h_src2[31:0], h_src1[31:0]};
            else
                instr_q[WIDTH-1] <= 1'b0;
        end
    end

    assign enq.o_ready = ready;
    assign o_count     = count;
    assign o_instr     = instr_q;
endmodule

// File: doc/mem_issue_queue.md
Name: mem_issue_queue

Overview:
- In-order issue queue for loads and stores, one stage upstream of the memory-calculation stage.
- Holds dispatched memory micro-ops until both source operands are available.
- Captures missing operands from two bypass buses (ALU and memory stage) and drops entries killed by branch mispredict.
- Issues the oldest entry as a packed, registered instruction word whose layout the memory stage unpacks directly.

Parameters:
- DEPTH, 8: number of entries; power of two, at least 2.
- WIDTH_REG, 5: physical register tag width.
- WIDTH_BRM, 4: branch mask width.
- WIDTH, 4*32+WIDTH_REG+WIDTH_BRM+18: packed issue word width. The memory stage must be instantiated with the same value.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_enq_val  in  1  dispatch valid.
- i_enq_uop  in  7  opcode.
- i_enq_func  in  10  funct / size code.
- i_enq_brmask  in  WIDTH_BRM  branch dependency mask.
- i_enq_rd  in  WIDTH_REG  destination tag.
- i_enq_pc  in  32  pc.
- i_enq_imm  in  32  immediate.
- i_enq_rs1, i_enq_rs2  in  WIDTH_REG each  source tags.
- i_enq_rdy1, i_enq_rdy2  in  1 each  source already available.
- i_enq_op1, i_enq_op2  in  32 each  source values (meaningful only when the matching rdy is 1).
- i_bypass_alu, i_bypass_mem  in  33+WIDTH_REG each  {val, tag, data}.
- i_br_kill  in  1  mispredict kill strobe.
- i_br_resolve  in  1  correct-prediction resolve strobe.
- i_br_mask  in  WIDTH_BRM  branch bit(s) for kill/resolve.
- o_ready  out  1  queue can accept dispatch.
- o_count  out  $clog2(DEPTH)+1  occupancy.
- o_instr  out  WIDTH  packed {val, uop, brmask, rd, pc, func, imm, op2, op1}, MSB first.

Behaviour:
- Reset (async): all entries invalid; head = tail = 0; o_count = 0; o_ready = 1; o_instr = 0.
- Storage: circular buffer. Each entry holds {valid, uop, func, brmask, rd, pc, imm, rs1, rdy1, op1, rs2, rdy2, op2}.
- Enqueue: accepted when i_enq_val && o_ready. The entry is written at tail and tail advances (wraps at DEPTH).
- o_ready = (count < DEPTH), computed from the registered count. A same-cycle issue does not free space for enqueue, so a full queue rejects dispatch even while issuing.
- Wakeup, each cycle, for every valid entry and for the incoming enqueue:
  - A source with rdy=0 and tag==bus.tag on a bus with val=1 captures bus.data and sets rdy=1.
  - If both buses match the same tag, the ALU bus wins.
  - Ready sources are never overwritten.
- Branch kill (i_br_kill): every stored entry with (brmask & i_br_mask) != 0 has valid cleared. An incoming enqueue whose mask matches is accepted (consumes a slot) but written invalid.
- Branch resolve (i_br_resolve): i_br_mask bits are cleared in every stored and incoming brmask.
- If kill and resolve are asserted in the same cycle, kill takes priority.
- Head handling, one action per cycle, evaluated on state before this cycle's updates:
  - Head entry invalid (killed) and count > 0: pop it without issuing; o_instr.val = 0 next cycle.
  - Head valid and rdy1 && rdy2 and not killed this cycle: pop it; next cycle o_instr = {1, uop, brmask & ~resolve mask, rd, pc, func, imm, op2, op1}.
  - Otherwise: no pop; o_instr.val = 0. Payload fields hold their last values.
- Latency: enqueue with both sources ready into an empty queue → o_instr valid 2 cycles after the enqueue edge (write, then issue register).
- Strictly in-order: a ready younger entry never passes a non-ready head.
- Issue rate: at most one per cycle. No back-pressure from downstream.
- Count update: count_next = count + enq_accepted - popped. Wraps on both pointers are handled modulo DEPTH.
- Reset asserted mid-operation clears everything immediately, including an in-flight o_instr.

Optional Feature:
- Macro: MEM_IQ_FAST_WAKEUP_EN.
- When defined: a head source matched by a bypass bus in the current cycle counts as ready for the issue decision. The bypass data is muxed directly into o_instr, so the head issues in the same cycle as the wakeup.
- When undefined: wakeup only writes the entry. The head issues no earlier than the cycle after the capture (one extra cycle of load-use latency).

Test Plan:
- Reset then enqueue lw (uop 0000011, rdy1=rdy2=1, op1=0x100, imm=4, rd=7) → o_instr.val=1 two cycles later with op1=0x100, imm=4, rd=7; o_count returns to 0.
- Enqueue store with rdy2=0, rs2=12. Three cycles later drive i_bypass_alu={1,12,0xDEADBEEF} → op2=0xDEADBEEF issued one cycle after the bypass (same cycle with MEM_IQ_FAST_WAKEUP_EN); no issue before.
- Fill 8 entries all not ready → o_ready=0, o_count=8; a 9th enqueue is ignored. Wake all via the bypass → 8 consecutive issues in enqueue order, with pointers wrapping.
- Entries A (brmask 0001) and B (0010) queued behind a stalled head; pulse i_br_kill with mask 0010 → B never issues, A issues, count decrements by both.
- i_br_resolve with mask 0001 while entry with brmask 0011 is queued → it issues with brmask 0010.
- Assert i_rst while the queue holds 5 entries → o_count=0, o_ready=1, o_instr=0 immediately; no issue after release.
